// File: rtl/is_weight_skew_feeder_if.sv
// Weight-vector stream into the skew feeder: valid/ready handshake with packed lanes and tile-last flag.
interface is_weight_skew_feeder_if #(
  parameter int WIDTH_B = 16,
  parameter int LANES   = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH_B-1:0] in_data;
  logic                     in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/is_weight_skew_feeder.sv
// Weight feeder for the input-stationary array: FIFO buffer, diagonal per-lane skew, tile drain.
// Optional starvation counter enabled by defining WFEED_STALL_COUNT_EN.
module is_weight_skew_feeder #(
  parameter int WIDTH_B = 16,
  parameter int LANES   = 4,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_clear,
  input  logic                     start,
  is_weight_skew_feeder_if.slave   wbus,
  output logic [LANES*WIDTH_B-1:0] wei_out,
  output logic [LANES-1:0]         lane_en,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LANES);
  localparam int DW = LANES * WIDTH_B;
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   drain_cnt_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [DW:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;

  logic            clear;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            start_ok;
  logic [DW:0]     head;

  assign clear    = !rst_n || reg_clear;
  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign push     = wbus.in_valid && !full;
  assign pop      = (state_reg == FEED) && !empty;
  // done_reg high means the tile just ended this cycle; a start here must not relaunch it
  assign start_ok = (state_reg == IDLE) && start && !done_reg;
  assign head     = mem[rd_ptr_reg];

  assign wbus.in_ready = !full;
  assign busy          = busy_reg;
  assign done          = done_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {wbus.in_last, wbus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg <= FEED;
            busy_reg  <= 1'b1;
          end
        end
        FEED: begin
          if (pop && head[DW]) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Lane gi owns gi+1 registers: the stage loaded on pop plus gi delay slots; the last one drives the port
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH_B-1:0] dat_reg [0:gi];
      logic [gi:0]        vld_reg;

      always_ff @(posedge clk) begin
        if (clear || state_reg == IDLE) begin
          for (int j = 0; j <= gi; j++) dat_reg[j] <= '0;
          vld_reg <= '0;
        end else begin
          dat_reg[0] <= pop ? head[gi*WIDTH_B +: WIDTH_B] : '0;
          vld_reg[0] <= pop;
          for (int j = 1; j <= gi; j++) begin
            dat_reg[j] <= dat_reg[j-1];
            vld_reg[j] <= vld_reg[j-1];
          end
        end
      end

      assign wei_out[gi*WIDTH_B +: WIDTH_B] = dat_reg[gi];
      assign lane_en[gi]                    = vld_reg[gi];
    end
  endgenerate

`ifdef WFEED_STALL_COUNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk) begin
    if (clear || start_ok) begin
      stall_reg <= '0;
    end else if (state_reg == FEED && empty && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_is_weight_skew_feeder.sv
// Directed bench for is_weight_skew_feeder (LANES=4, DEPTH=4, WIDTH_B=16).
module tb_is_weight_skew_feeder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_clear;
  logic        start;
  logic [63:0] wei_out;
  logic [3:0]  lane_en;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

`ifdef WFEED_STALL_COUNT_EN
  localparam logic [15:0] STALL_EXP = 16'd4;
  localparam int          STALL_ON  = 1;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
  localparam int          STALL_ON  = 0;
`endif

  is_weight_skew_feeder_if #(.WIDTH_B(16), .LANES(4)) wbus ();

  is_weight_skew_feeder #(.WIDTH_B(16), .LANES(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_clear (reg_clear),
    .start     (start),
    .wbus      (wbus),
    .wei_out   (wei_out),
    .lane_en   (lane_en),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec(input logic [15:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic push(input logic [63:0] d, input logic l);
    wbus.in_valid = 1'b1;
    wbus.in_data  = d;
    wbus.in_last  = l;
    tick();
    wbus.in_valid = 1'b0;
    wbus.in_last  = 1'b0;
  endtask

  // Called in the first cycle after start was accepted, with n vectors (base+4i, last on n-1) queued.
  // Vector i is popped at edge s+1+i, so lane k shows it in cycle s+2+i+k; done lands at s+n+5.
  task automatic check_skew(input int base, input int n);
    logic [63:0] ew;
    logic [3:0]  ee;
    int          i;
    for (int c = 1; c <= n + 6; c++) begin
      ew = '0;
      ee = '0;
      for (int k = 0; k < 4; k++) begin
        i = c - 2 - k;
        if (i >= 0 && i < n) begin
          ee[k] = 1'b1;
          ew[k*16 +: 16] = 16'(base + k + 4 * i);
        end
      end
      check($sformatf("skew%0h c%0d wei_out", base, c), wei_out, ew);
      check($sformatf("skew%0h c%0d lane_en", base, c), 64'(lane_en), 64'(ee));
      check($sformatf("skew%0h c%0d done", base, c), 64'(done), 64'(c == n + 5));
      check($sformatf("skew%0h c%0d busy", base, c), 64'(busy), 64'(c <= n + 4));
      if (c < n + 6) tick();
    end
    $display("tile base=%0h vectors=%0d observed", base, n);
  endtask

  initial begin
    int acc;
    rst_n         = 1'b0;
    reg_clear     = 1'b0;
    start         = 1'b0;
    wbus.in_valid = 1'b0;
    wbus.in_data  = '0;
    wbus.in_last  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst in_ready", 64'(wbus.in_ready), 64'd1);
    check("rst wei_out", wei_out, 64'd0);
    check("rst lane_en", 64'(lane_en), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stall_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // Preload four vectors in IDLE, then one start
    for (int v = 0; v < 4; v++) push(vec(16'(16'h10 + 4 * v)), v == 3);
    check("preload full in_ready", 64'(wbus.in_ready), 64'd0);
    check("preload idle lane_en", 64'(lane_en), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_skew(16'h10, 4);

    // Backpressure: six offers, only four accepted
    acc = 0;
    for (int v = 0; v < 6; v++) begin
      wbus.in_valid = 1'b1;
      wbus.in_data  = vec(16'(16'h100 + 4 * v));
      wbus.in_last  = (v == 3);
      if (wbus.in_ready) acc++;
      tick();
    end
    wbus.in_valid = 1'b0;
    wbus.in_last  = 1'b0;
    check("bp accepts", 64'(acc), 64'd4);
    check("bp in_ready low", 64'(wbus.in_ready), 64'd0);
    $display("backpressure accepted=%0d", acc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_skew(16'h100, 4);

    // Starvation: first push with start, then every third cycle
    start         = 1'b1;
    wbus.in_valid = 1'b1;
    wbus.in_data  = vec(16'h200);
    wbus.in_last  = 1'b0;
    tick();
    start         = 1'b0;
    wbus.in_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c >= 2 && c <= 8) begin
        check($sformatf("starve c%0d lane0", c), 64'(wei_out[15:0]),
              (c == 2) ? 64'h200 : (c == 5) ? 64'h204 : (c == 8) ? 64'h208 : 64'h0);
        check($sformatf("starve c%0d lane_en0", c), 64'(lane_en[0]), 64'(c == 2 || c == 5 || c == 8));
      end
      if (c == 11 || c == 12) check($sformatf("starve c%0d done", c), 64'(done), 64'(c == 12));
      if (c == 12) check("starve stall_cnt", 64'(stall_cnt), 64'(STALL_EXP));
      wbus.in_valid = (c == 3 || c == 6);
      wbus.in_data  = vec((c == 3) ? 16'h204 : 16'h208);
      wbus.in_last  = (c == 6);
      tick();
      wbus.in_valid = 1'b0;
      wbus.in_last  = 1'b0;
    end
    $display("starvation tile stall_cnt=%0d", stall_cnt);

    // Mid-tile clear two cycles after first pop
    push(vec(16'h300), 1'b0);
    push(vec(16'h304), 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("clr pre busy", 64'(busy), 64'd1);
    check("clr pre lane_en", 64'(lane_en), 64'h3);
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    check("clr lane_en", 64'(lane_en), 64'd0);
    check("clr wei_out", wei_out, 64'd0);
    check("clr busy", 64'(busy), 64'd0);
    check("clr in_ready", 64'(wbus.in_ready), 64'd1);
    check("clr stall_cnt", 64'(stall_cnt), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("empty c%0d lane_en", c), 64'(lane_en), 64'd0);
      check($sformatf("empty c%0d busy", c), 64'(busy), 64'd1);
      check($sformatf("empty c%0d stall", c), 64'(stall_cnt), 64'(STALL_ON * (c - 1)));
      tick();
    end
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    check("clr2 busy", 64'(busy), 64'd0);
    $display("mid-tile clear done");

    // Single vector with start held high throughout, including the done cycle
    push(vec(16'h400), 1'b1);
    start = 1'b1;
    tick();
    check_skew(16'h400, 1);
    start = 1'b0;
    tick();
    check("hold start idle busy", 64'(busy), 64'd0);

    // Back-to-back: second tile preloaded during the first tile's drain
    push(vec(16'h500), 1'b0);
    push(vec(16'h504), 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("b2b c%0d done", c), 64'(done), 64'(c == 7));
      check($sformatf("b2b c%0d busy", c), 64'(busy), 64'(c <= 6));
      wbus.in_valid = (c == 3 || c == 4);
      wbus.in_data  = vec((c == 3) ? 16'h600 : 16'h604);
      wbus.in_last  = (c == 4);
      if (c < 8) tick();
      wbus.in_valid = 1'b0;
      wbus.in_last  = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_skew(16'h600, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/is_weight_skew_feeder.md
# is_weight_skew_feeder

Upstream feeder for the input-stationary systolic array. It buffers packed weight vectors from memory in a small FIFO. Each accepted vector is fanned out to the array's LANES weight inputs with a diagonal skew: lane k is delayed k cycles. A per-lane valid (`lane_en`) drives each edge PE's `pipeline_en`/`cell_en`. The feeder inserts bubbles when starved and flushes the skew after the last vector of a tile.

## Interface
Parameters:
- `WIDTH_B`, 16: weight element width.
- `LANES`, 4: number of array rows fed (≥2).
- `DEPTH`, 4: FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `reg_clear`  in  1: synchronous clear, same effect as reset.
- `start`  in  1: begin feeding a tile. Honoured only in IDLE.
- `in_valid`  in  1: input vector valid.
- `in_ready`  out  1: FIFO can accept.
- `in_data`  in  LANES*WIDTH_B: packed weights. Lane k is `[k*WIDTH_B +: WIDTH_B]`.
- `in_last`  in  1: marks the final vector of a tile.
- `wei_out`  out  LANES*WIDTH_B: skewed weights to the array edge.
- `lane_en`  out  LANES: per-lane data valid.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse when the tile is fully flushed.
- `stall_cnt`  out  16: starvation counter (see Configuration).

## Operation
- FIFO: DEPTH entries of {in_data, in_last}. Push on `in_valid && in_ready`. `in_ready = !full`, with no bypass when full, so a full FIFO refuses input even when a pop happens in the same cycle. Pushes are accepted in every state, including IDLE preload.
- FSM states: IDLE, FEED, DRAIN.
  - IDLE → FEED on `start`.
  - FEED, FIFO non-empty: pop one entry. Lane-0 stage loads the data with valid=1. Lane k stage loads lane k's element into the head of a k-deep shift chain.
  - FEED, FIFO empty: inject a bubble (data 0, valid 0) into the chains. The state does not change.
  - FEED → DRAIN when the popped entry has `last`=1. DRAIN counter loads LANES-1.
  - DRAIN: inject bubbles and decrement the counter. At 0 → IDLE with `done`=1 in that same cycle.
- All chains advance every cycle while in FEED or DRAIN. In IDLE the chains hold zero and `lane_en` is 0.
- `in_last` on an entry still in the FIFO after `done` belongs to the next tile and is unaffected.
- `start` in FEED/DRAIN is ignored. A `start` in the same cycle as `done` is ignored; the tile has already ended.
- Outputs are registered: `wei_out` lane k = chain tail k, `lane_en[k]` = tail valid k.
- Reset / `reg_clear`: FIFO emptied, all chains zero, state IDLE, `done`=0, `stall_cnt`=0. This applies mid-tile too; partially fed data is discarded.

## Timing
- Reset values: `in_ready`=1 after the reset edge. `wei_out`=0, `lane_en`=0, `busy`=0, `done`=0, `stall_cnt`=0.
- Push at edge t: entry is visible (non-empty) from cycle t+1.
- Pop at edge p: lane 0 is valid in cycle p+1, and lane k is valid in cycle p+1+k.
- With a continuous supply, lane 0 carries one vector per cycle with no gaps.
- `done` is asserted in the cycle after the last vector's lane LANES-1 output cycle, i.e. `done` at p_last+LANES+1. `busy` drops in that same cycle.
- Throughput is one vector per cycle. FIFO count is updated with simultaneous push and pop (net 0).

## Configuration
- `WFEED_STALL_COUNT_EN` defined: `stall_cnt` increments, saturating at 0xFFFF, on every FEED cycle in which the FIFO is empty (a bubble is injected). It clears on reset, on `reg_clear` and on `start` acceptance.
- Not defined: no counter logic; `stall_cnt` is tied to 0.

## Test plan
All scenarios use LANES=4, DEPTH=4, WIDTH_B=16.
- Preload/skew: push vectors V0..V3 in IDLE, with {lane3..lane0}={0x13,0x12,0x11,0x10}+4i and `in_last` on V3, then pulse `start`.
  - Lane 0 shows 0x10,0x14,0x18,0x1C on 4 consecutive cycles; lane 3 shows 0x13.. starting 3 cycles later.
  - `done` pulses exactly once, 4 cycles after lane 0's last value.
- Backpressure: in IDLE, hold `in_valid`=1 for 6 cycles. `in_ready` falls after 4 accepts; only 4 entries are stored.
- Starvation: `start`, then push one vector every 3rd cycle, with the 3rd vector having last=1.
  - Lane 0 shows each vector followed by two bubbles with `lane_en[0]`=0.
  - `stall_cnt`=4 at `done` with the macro defined, and 0 without it.
- Mid-tile clear: assert `reg_clear` two cycles after the first pop. Next cycle: all `lane_en`=0, `wei_out`=0, `busy`=0, `in_ready`=1; later `start` with an empty FIFO produces only bubbles.
- Start edge cases:
  - `start` while busy: ignored, no restart.
  - A single vector with last=1: `done` at pop+5.
  - Back-to-back tiles: a 2nd tile's entries preloaded during DRAIN are retained and are fed after the next `start`.
